// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32 core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait watchdog and retired-instruction counter. Optional macro: ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             funct3_0,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_en,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [2:0]       ALUOP,
    output logic             mem_fault,
    output logic [CNT_W-1:0] instr_retired
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal_instr
`endif
);

    localparam int unsigned WD_W = 8;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_RT   = 3'b010;
    localparam logic [2:0] ALU_IA   = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LUI, MEM_ADDR, MEM_RD,
        MEM_WB, MEM_WR, ALU_WB, BRANCH, JAL, FAULT, TRAP
    } state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            wait_st_c, wd_limit_c, retire_c;

    logic            mem_req_q, mem_req_d;
    logic            mem_write_q, mem_write_d;
    logic            adr_src_q, adr_src_d;
    logic            reg_write_q, reg_write_d;
    logic [1:0]      src_a_q, src_a_d;
    logic [1:0]      src_b_q, src_b_d;
    logic [1:0]      res_q, res_d;
    logic [2:0]      aluop_q, aluop_d;
    logic            fault_q, fault_d;
`ifdef ILLEGAL_TRAP_EN
    logic            illegal_q, illegal_d;
`endif

    // Next state, watchdog, retire strobe and lookahead-decoded Moore outputs
    always_comb begin
        state_d     = state_q;
        retire_c    = 1'b0;
        wait_st_c   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
        wd_limit_c  = (wd_q == WD_W'(MEM_WAIT_MAX - 1));

        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH: begin
                if (mem_ready)       state_d = DECODE;
                else if (wd_limit_c) state_d = FAULT;
            end
            DECODE: begin
                case (opcode)
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = EXEC_LUI;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d  = FETCH;
                        retire_c = 1'b1;
`endif
                    end
                endcase
            end
            EXEC_R, EXEC_I, EXEC_LUI: state_d = ALU_WB;
            MEM_ADDR: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready)       state_d = MEM_WB;
                else if (wd_limit_c) state_d = FAULT;
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_d  = FETCH;
                    retire_c = 1'b1;
                end else if (wd_limit_c) begin
                    state_d = FAULT;
                end
            end
            MEM_WB, ALU_WB, BRANCH: begin
                state_d  = FETCH;
                retire_c = 1'b1;
            end
            JAL:      state_d = ALU_WB;
            FAULT:    state_d = FAULT;
            TRAP:     state_d = TRAP;
            default:  state_d = IDLE;
        endcase

        wd_d = wd_q;
        if (state_d != state_q)          wd_d = '0;
        else if (wait_st_c && !mem_ready) wd_d = wd_q + WD_W'(1);

        cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;

        mem_req_d   = 1'b0;
        mem_write_d = 1'b0;
        adr_src_d   = 1'b0;
        reg_write_d = 1'b0;
        src_a_d     = 2'b00;
        src_b_d     = 2'b00;
        res_d       = 2'b00;
        aluop_d     = ALU_ADD;
        fault_d     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = 1'b0;
`endif
        case (state_d)
            FETCH: begin
                mem_req_d = 1'b1;
                src_b_d   = 2'b10;
                res_d     = 2'b10;
            end
            DECODE: begin
                src_a_d = 2'b01;
                src_b_d = 2'b01;
            end
            EXEC_R: begin
                src_a_d = 2'b10;
                aluop_d = ALU_RT;
            end
            EXEC_I: begin
                src_a_d = 2'b10;
                src_b_d = 2'b01;
                aluop_d = ALU_IA;
            end
            EXEC_LUI: begin
                src_b_d = 2'b01;
                aluop_d = ALU_PASS;
            end
            MEM_ADDR: begin
                src_a_d = 2'b10;
                src_b_d = 2'b01;
            end
            MEM_RD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
            end
            MEM_WB: begin
                res_d       = 2'b01;
                reg_write_d = 1'b1;
            end
            MEM_WR: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                adr_src_d   = 1'b1;
            end
            ALU_WB:   reg_write_d = 1'b1;
            BRANCH: begin
                src_a_d = 2'b10;
                aluop_d = ALU_SUB;
            end
            JAL: begin
                src_a_d = 2'b01;
                src_b_d = 2'b10;
            end
            FAULT:    fault_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     illegal_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            adr_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            src_a_q     <= 2'b00;
            src_b_q     <= 2'b00;
            res_q       <= 2'b00;
            aluop_q     <= ALU_ADD;
            fault_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            adr_src_q   <= adr_src_d;
            reg_write_q <= reg_write_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            res_q       <= res_d;
            aluop_q     <= aluop_d;
            fault_q     <= fault_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    // Fetch handshake and branch outcome must act in the same cycle as mem_ready / zero
    assign ir_write = (state_q == FETCH) && mem_ready;
    assign pc_en    = ((state_q == FETCH) && mem_ready) || (state_q == JAL) ||
                      ((state_q == BRANCH) && (zero ^ funct3_0));

    assign mem_req       = mem_req_q;
    assign mem_write     = mem_write_q;
    assign adr_src       = adr_src_q;
    assign reg_write     = reg_write_q;
    assign alu_src_a     = src_a_q;
    assign alu_src_b     = src_b_q;
    assign result_src    = res_q;
    assign ALUOP         = aluop_q;
    assign mem_fault     = fault_q;
    assign instr_retired = cnt_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`endif

endmodule
